// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter and the bus decoder
// that sits behind it.
//
// Contents:
//   arb_state_t      - arbiter FSM state (idle, granted to m0, granted to m1)
//   GNT_*            - one-hot grant encodings driven on gnt_o (bit0 = m0)
//   WB_AW / WB_DW    - default address and data widths
//   RAM_REGION_MASK  - address bits that must be zero for a RAM access
//   in_ram_region()  - address decode helper for the RAM region
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS0 = 2'd1,
        ST_BUS1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    // RAM occupies the bottom 256 KiB: address bits [31:18] are all zero.
    localparam logic [31:0] RAM_REGION_MASK = 32'hFFFC_0000;

    function automatic logic in_ram_region(input logic [31:0] adr);
        return (adr & RAM_REGION_MASK) == 32'h0000_0000;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-beat transfer watchdog.
//
// Counts consecutive cycles in which a strobed beat waits for its ack and
// pulses timeout for one cycle on the TIMEOUT-th such cycle, so a missing
// slave turns into an error instead of a hung master.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   active   in   a beat is on the bus (cyc & stb of the granted master)
//   ack      in   slave acknowledge for the current beat
//   restart  in   arbiter state is changing this cycle
//   timeout  out  single-cycle error pulse for the waiting beat
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    input  logic restart,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // An ack in the final cycle beats the timeout, so ack masks the pulse.
    assign timeout = active && !ack && (count == LIMIT);

    // The counter restarts for every beat; it also clears on the timeout
    // pulse itself, so it never needs to count past LIMIT.
    always_ff @(posedge clk) begin
        if (rst || !active || ack || restart || timeout) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: shares one slave-side bus between the CPU
// instruction-fetch port (m0) and the data/load-store port (m1).
//
// Round-robin grant taken from the registered state; the granted master
// keeps the bus for as long as it holds cyc. Every hand-over passes through
// one idle cycle. A watchdog turns a missing ack into a one-cycle err.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_* / m1_*              master ports (adr/dat/we/cyc/stb in,
//                            dat/ack/err out)
//   s_adr_o .. s_stb_o       slave-side request, muxed from the granted master
//   s_dat_i, s_ack_i         slave-side response
//   gnt_o                    one-hot current grant, bit0 = m0, 00 when idle
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_gnt;
    logic       state_change;
    logic       wd_timeout;

    // State register. last_gnt remembers who owned the bus most recently so
    // a simultaneous request goes to the other master; it starts at m1 so
    // m0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next == ST_BUS0) begin
                last_gnt <= 1'b0;
            end else if (state_next == ST_BUS1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    // Next-state logic. Once granted, the owner's cyc locks the bus and the
    // other master's request is ignored until the owner lets go.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_gnt ? ST_BUS0 : ST_BUS1;
                end else if (m0_cyc_i) begin
                    state_next = ST_BUS0;
                end else if (m1_cyc_i) begin
                    state_next = ST_BUS1;
                end
            end
            ST_BUS0: begin
                if (!m0_cyc_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUS1: begin
                if (!m1_cyc_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign state_change = (state_next != state);

    // Slave-side mux. Control outputs are forced low while rst is held so a
    // transfer in flight is dropped in the reset cycle itself, not one later.
    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        gnt_o   = GNT_NONE;
        if (state == ST_BUS1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
        if (!rst) begin
            case (state)
                ST_BUS0: begin
                    s_we_o  = m0_we_i;
                    s_cyc_o = m0_cyc_i;
                    s_stb_o = m0_stb_i;
                    gnt_o   = GNT_M0;
                end
                ST_BUS1: begin
                    s_we_o  = m1_we_i;
                    s_cyc_o = m1_cyc_i;
                    s_stb_o = m1_stb_i;
                    gnt_o   = GNT_M1;
                end
                default: begin
                    gnt_o = GNT_NONE;
                end
            endcase
        end
    end

    // Read data is broadcast; ack/err are routed only to the granted master,
    // so acks arriving while idle or after cyc has dropped are discarded.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i && gnt_o[0] && m0_stb_i;
    assign m1_ack_o = s_ack_i && gnt_o[1] && m1_stb_i;
    assign m0_err_o = wd_timeout && gnt_o[0];
    assign m1_err_o = wd_timeout && gnt_o[1];

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (s_cyc_o && s_stb_o),
        .ack     (s_ack_i),
        .restart (state_change),
        .timeout (wd_timeout)
    );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m (TIMEOUT = 8).
// A cycle-level reference model (owner / last owner / wait counter kept as
// plain integers) predicts every output each cycle; directed sequences add
// scenario-level checks on grant order, ack counts and error timing.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic          m0_we_i, m0_cyc_i, m0_stb_i;
    logic          m1_we_i, m1_cyc_i, m1_stb_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    int num_vectors = 0;
    int num_miscompares = 0;

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // and how many strobed cycles the current beat has already waited.
    int owner = -1;
    int last_owner = 1;
    int wait_cnt = 0;

    int   ack0_cnt, ack1_cnt, err0_cnt, err1_cnt;
    logic ack1_now, err1_now;
    int   ack_pct;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_vectors++;
        if (got !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearInputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0;
    endtask

    task automatic clearCounts();
        ack0_cnt = 0; ack1_cnt = 0; err0_cnt = 0; err1_cnt = 0;
    endtask

    // One bus cycle: check all outputs against the model at the falling
    // edge, then advance the model across the rising edge.
    task automatic applyStimulus();
        logic [1:0]    e_gnt;
        logic          e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic          strobed;
        int            nxt;
        @(negedge clk);
        e_gnt = 2'b00; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
        e_adr = m0_adr_i; e_dat = m0_dat_i;
        if (!rst && owner == 0) begin
            e_gnt = 2'b01; e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i;
            e_adr = m0_adr_i; e_dat = m0_dat_i;
            e_ack0 = s_ack_i && m0_stb_i;
            e_err0 = m0_cyc_i && m0_stb_i && !s_ack_i && (wait_cnt == TIMEOUT - 1);
        end else if (!rst && owner == 1) begin
            e_gnt = 2'b10; e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i;
            e_adr = m1_adr_i; e_dat = m1_dat_i;
            e_ack1 = s_ack_i && m1_stb_i;
            e_err1 = m1_cyc_i && m1_stb_i && !s_ack_i && (wait_cnt == TIMEOUT - 1);
        end
        checkOutput("gnt", 64'(gnt_o), 64'(e_gnt));
        checkOutput("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
        checkOutput("s_stb", 64'(s_stb_o), 64'(e_stb));
        checkOutput("s_we", 64'(s_we_o), 64'(e_we));
        if (!rst && owner >= 0) begin
            checkOutput("s_adr", 64'(s_adr_o), 64'(e_adr));
            checkOutput("s_dat", 64'(s_dat_o), 64'(e_dat));
        end
        checkOutput("m0_ack", 64'(m0_ack_o), 64'(e_ack0));
        checkOutput("m1_ack", 64'(m1_ack_o), 64'(e_ack1));
        checkOutput("m0_err", 64'(m0_err_o), 64'(e_err0));
        checkOutput("m1_err", 64'(m1_err_o), 64'(e_err1));
        checkOutput("m0_rdat", 64'(m0_dat_o), 64'(s_dat_i));
        checkOutput("m1_rdat", 64'(m1_dat_o), 64'(s_dat_i));
        ack0_cnt += int'(m0_ack_o); ack1_cnt += int'(m1_ack_o);
        err0_cnt += int'(m0_err_o); err1_cnt += int'(m1_err_o);
        ack1_now = m1_ack_o; err1_now = m1_err_o;
        @(posedge clk);
        if (rst) begin
            owner = -1; last_owner = 1; wait_cnt = 0;
        end else begin
            strobed = e_cyc && e_stb;
            if (owner < 0) begin
                if (m0_cyc_i && m1_cyc_i) nxt = (last_owner == 0) ? 1 : 0;
                else if (m0_cyc_i)        nxt = 0;
                else if (m1_cyc_i)        nxt = 1;
                else                      nxt = -1;
            end else begin
                nxt = ((owner == 0) ? m0_cyc_i : m1_cyc_i) ? owner : -1;
            end
            if (strobed && !s_ack_i && wait_cnt < TIMEOUT - 1 && nxt == owner) wait_cnt++;
            else wait_cnt = 0;
            if (nxt >= 0) last_owner = nxt;
            owner = nxt;
        end
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        clearInputs();
        clearCounts();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset_gnt", 64'(gnt_o), 64'h0);
        checkOutput("reset_cyc", 64'(s_cyc_o), 64'h0);

        // Single read from m0, slave acks in the second bus cycle.
        clearCounts();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
        applyStimulus();
        checkOutput("rd_cyc_c1", 64'(s_cyc_o), 64'h1);
        checkOutput("rd_gnt_c1", 64'(gnt_o), 64'h1);
        applyStimulus();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        checkOutput("rd_ack_c2", 64'(m0_ack_o), 64'h1);
        checkOutput("rd_dat_c2", 64'(m0_dat_o), 64'hDEAD_BEEF);
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("rd_ack_total", 64'(ack0_cnt), 64'd1);
        checkOutput("rd_m1_ack", 64'(ack1_cnt), 64'd0);

        // Tie after reset, hand-over through idle, then round-robin tie.
        doReset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        applyStimulus();
        checkOutput("tie_first", 64'(gnt_o), 64'h1);
        s_ack_i = 1'b1;
        applyStimulus();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        applyStimulus();
        checkOutput("tie_idle", 64'(gnt_o), 64'h0);
        applyStimulus();
        checkOutput("tie_m1", 64'(gnt_o), 64'h2);
        s_ack_i = 1'b1;
        applyStimulus();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        applyStimulus();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        applyStimulus();
        checkOutput("tie_rr", 64'(gnt_o), 64'h1);
        clearInputs();
        applyStimulus();

        // Locked 4-beat burst on m0 while m1 keeps requesting.
        clearCounts();
        m0_cyc_i = 1'b1;
        applyStimulus();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m0_stb_i = 1'b1; s_ack_i = 1'b0; m0_adr_i = 32'h200 + 32'(4 * b);
            applyStimulus();
            checkOutput("burst_gnt_wait", 64'(gnt_o), 64'h1);
            s_ack_i = 1'b1; s_dat_i = $urandom;
            applyStimulus();
            checkOutput("burst_gnt_ack", 64'(gnt_o), 64'h1);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        applyStimulus();
        checkOutput("burst_gap", 64'(gnt_o), 64'h0);
        applyStimulus();
        checkOutput("burst_m1", 64'(gnt_o), 64'h2);
        checkOutput("burst_acks", 64'(ack0_cnt), 64'd4);

        // Write through m1 while it holds the bus.
        clearCounts();
        m1_we_i = 1'b1; m1_adr_i = 32'h0000_0040; m1_dat_i = 32'h1234_5678;
        #1;
        checkOutput("wr_we", 64'(s_we_o), 64'h1);
        checkOutput("wr_dat", 64'(s_dat_o), 64'h1234_5678);
        checkOutput("wr_adr", 64'(s_adr_o), 64'h0000_0040);
        applyStimulus();
        s_ack_i = 1'b1;
        applyStimulus();
        checkOutput("wr_m1_ack", 64'(ack1_cnt), 64'd1);
        checkOutput("wr_m0_ack", 64'(ack0_cnt), 64'd0);
        clearInputs();
        applyStimulus();

        // Timeout: no ack, err in the 8th strobed cycle only.
        clearCounts();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        applyStimulus();
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus();
            checkOutput("to_err_beat", 64'(err1_now), 64'(i == TIMEOUT));
        end
        checkOutput("to_err_total", 64'(err1_cnt), 64'd1);
        checkOutput("to_no_ack", 64'(ack1_cnt), 64'd0);
        clearInputs();
        applyStimulus();

        // Timeout race: ack arrives in the would-be error cycle.
        clearCounts();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        applyStimulus();
        for (int i = 1; i < TIMEOUT; i++) applyStimulus();
        s_ack_i = 1'b1;
        applyStimulus();
        checkOutput("race_ack", 64'(ack1_now), 64'h1);
        checkOutput("race_no_err", 64'(err1_cnt), 64'd0);
        clearInputs();
        applyStimulus();

        // Reset in the middle of an m1 transfer.
        clearCounts();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b1; s_ack_i = 1'b1;
        applyStimulus();
        rst = 1'b0; s_ack_i = 1'b0;
        checkOutput("rstmid_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("rstmid_gnt", 64'(gnt_o), 64'h0);
        checkOutput("rstmid_ack_err", 64'(ack1_cnt + err1_cnt), 64'd0);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        applyStimulus();
        checkOutput("rstmid_tie", 64'(gnt_o), 64'h1);
        clearInputs();
        applyStimulus();

        // Randomized traffic, with ack-starved windows to provoke timeouts.
        ack_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) ack_pct = ($urandom_range(2) == 0) ? 0 : 40;
            rst = ($urandom_range(199) == 0);
            if (m0_cyc_i) m0_cyc_i = ($urandom_range(7) != 0);
            else          m0_cyc_i = ($urandom_range(3) == 0);
            if (m1_cyc_i) m1_cyc_i = ($urandom_range(7) != 0);
            else          m1_cyc_i = ($urandom_range(3) == 0);
            m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
            m0_we_i  = 1'($urandom_range(1));
            m1_we_i  = 1'($urandom_range(1));
            m0_adr_i = $urandom; m0_dat_i = $urandom;
            m1_adr_i = $urandom; m1_dat_i = $urandom;
            s_ack_i  = ($urandom_range(99) < 32'(ack_pct));
            s_dat_i  = $urandom;
            applyStimulus();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
